// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer: operands are processed LSB first through one full-adder cell.
// Optional macro SERIAL_ADDSUB_OVF_EN builds the signed-overflow logic; otherwise overflow is tied to 0.
module serial_addsub_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   // Returns {carry, sum} of a one-bit full adder.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic [CW-1:0]    r_cnt;
   logic             r_smode;
   logic             r_c;
   logic             r_carry;
   logic             r_busy;
   logic             r_done;

   logic       w_b;
   logic [1:0] w_fa;
   logic       w_s;
   logic       w_c;
   logic       w_last;

   // Subtraction inverts B and relies on the carry flop preloaded with 1.
   assign w_b    = r_sb[0] ^ r_smode;
   assign w_fa   = full_add(r_sa[0], w_b, r_c);
   assign w_s    = w_fa[0];
   assign w_c    = w_fa[1];
   assign w_last = (r_cnt == CNT_LAST);

   // Sequencer FSM, serial datapath and registered result fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_sa     <= '0;
         r_sb     <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_smode  <= 1'b0;
         r_c      <= 1'b0;
         r_carry  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sa    <= a_in;
                  r_sb    <= b_in;
                  r_smode <= mode;
                  r_c     <= mode;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= {w_s, r_acc[WIDTH-1:1]};
               r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
               r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
               r_c   <= w_c;
               r_cnt <= r_cnt + CNT_ONE;
               if (w_last) begin
                  r_result <= {w_s, r_acc[WIDTH-1:1]};
                  r_carry  <= w_c;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

   logic r_cmsb;
   logic r_ovf;

   // Carry into the MSB is the carry-out of bit WIDTH-2; compare it with the final carry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cmsb <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (r_state == S_RUN) begin
         if (r_cnt == CNT_PENULT) begin
            r_cmsb <= w_c;
         end
         if (w_last) begin
            r_ovf <= r_cmsb ^ w_c;
         end
      end
   end

   assign overflow = r_ovf;
`else
   assign overflow = 1'b0;
`endif

   assign busy      = r_busy;
   assign done      = r_done;
   assign result    = r_result;
   assign carry_out = r_carry;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Scoreboard bench for serial_addsub_seq: expected results are queued at start, a monitor checks on done.
module tb_serial_addsub_seq;

   localparam int WIDTH = 8;
`ifdef SERIAL_ADDSUB_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             cy;
      logic             ov;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a_in = '0;
   logic [WIDTH-1:0] b_in = '0;
   logic             mode = 1'b0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;

   serial_addsub_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .mode(mode),
      .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("result", 32'(result), 32'(e.res));
               chk("carry_out", 32'(carry_out), 32'(e.cy));
               chk("overflow", 32'(overflow), 32'(e.ov));
            end
         end
      end
   end

   task automatic pulse_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic m);
      @(negedge clk);
      a_in = a; b_in = b; mode = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits (bounded) for busy to drop, checking busy length and done position.
   task automatic wait_idle(input string name);
      int n;
      int done_at;
      n = 0;
      done_at = 0;
      while (busy === 1'b1 && n < 50) begin
         n++;
         if (done === 1'b1) done_at = n;
         @(negedge clk);
      end
      chk({name, "_busy_cycles"}, 32'(n), 32'(WIDTH + 1));
      chk({name, "_done_cycle"}, 32'(done_at), 32'(WIDTH + 1));
   endtask

   task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic m, input logic [WIDTH-1:0] er, input logic ec, input logic ev);
      sb_q.push_back('{res: er, cy: ec, ov: ev});
      pulse_start(a, b, m);
      wait_idle(name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_carry", 32'(carry_out), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("add_25_13", 8'h25, 8'h13, 1'b0, 8'h38, 1'b0, 1'b0);
      chk("hold_result", 32'(result), 32'h38);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("sub_50_30", 8'h50, 8'h30, 1'b1, 8'h20, 1'b1, 1'b0);
      run_op("sub_30_50", 8'h30, 8'h50, 1'b1, 8'hE0, 1'b0, 1'b0);
      run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_ON);
      run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, OVF_ON);
      run_op("sub_5a_00", 8'h5A, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0);
      run_op("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);

      // Start re-pulsed while running must be ignored.
      sb_q.push_back('{res: 8'h33, cy: 1'b0, ov: 1'b0});
      pulse_start(8'h11, 8'h22, 1'b0);
      a_in = 8'hAA; b_in = 8'h55; mode = 1'b1;
      pulse_start(8'hAA, 8'h55, 1'b1);
      while (busy === 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("ignored_start_idle", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      chk("ignored_start_no_rerun", 32'(busy), 32'd0);

      // Reset during RUN cycle 3 aborts with no done pulse.
      pulse_start(8'h44, 8'h11, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_carry", 32'(carry_out), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run_op("after_abort", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

      repeat (4) @(negedge clk);
      chk("queue_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_addsub_seq.md
Name: serial_addsub_seq

Overview:
Bit-serial sequencer wrapped around a one-bit add/subtract cell. Accepts two WIDTH-bit operands plus a mode bit, then processes one bit per clock, LSB first, through the cell. A registered carry/borrow flop carries state between bits. It reassembles the serial sum bits into a parallel result and hands that result to the downstream logic with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  synchronous reset, active-high
start  input  1  request pulse; sampled only in IDLE
a_in  input  WIDTH  operand A; captured on the accepted start edge
b_in  input  WIDTH  operand B; captured on the accepted start edge
mode  input  1  0 = A+B, 1 = A-B; captured on the accepted start edge
busy  output  1  high while an operation is in progress (RUN or DONE)
done  output  1  one-cycle pulse; result fields are valid from this cycle onward
result  output  WIDTH  A+B or A-B, modulo 2^WIDTH
carry_out  output  1  final carry; in subtract mode 1 = no borrow (A>=B unsigned)
overflow  output  1  signed two's-complement overflow (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state changes happen on the rising edge of clk.
- Reset: state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0; internal shift registers, bit counter and carry flop cleared.
- Reset mid-operation aborts immediately. The operation is lost, no done pulse is issued, and all outputs return to their reset values on that edge.
- rst has priority over start.
- FSM states: IDLE, RUN, DONE.
- IDLE + start=1:
  - capture a_in, b_in and mode into shift registers sa, sb and smode.
  - load carry flop c = mode (the +1 of the two's complement).
  - clear the bit counter; go to RUN; busy=1 from the next cycle.
- IDLE + start=0: stay in IDLE; outputs hold their last values.
- RUN, each cycle (bit i = counter value):
  - b' = sb[0] ^ smode.
  - s = sa[0] ^ b' ^ c.
  - next c = (sa[0]&b') | (sa[0]&c) | (b'&c).
  - shift s into the MSB of an internal accumulator; shift sa and sb right by one; increment the counter.
  - record c_msb_in = c when i = WIDTH-1.
- RUN -> DONE on the edge that processes bit WIDTH-1, i.e. after exactly WIDTH RUN cycles. On that edge:
  - result <= accumulator with the final bit included.
  - carry_out <= final c.
  - overflow <= c_msb_in ^ final c.
- DONE: done=1 and busy=1 for exactly one cycle, then unconditionally to IDLE; busy=0 from that edge.
- Latency: start accepted on edge E0. done is high in the cycle after edge E(WIDTH) and low again after E(WIDTH+1). Throughput is one operation per WIDTH+2 cycles.
- start while busy (RUN or DONE): ignored, not queued. Operands seen at that time have no effect.
- Output stability: result, carry_out and overflow change only on the DONE-entry edge or on reset. They hold between operations.
- Width rules:
  - result is truncated to WIDTH bits.
  - mode=1 with b_in=0 gives result=a_in, carry_out=1.
  - mode=0 with a_in=b_in=all-ones gives result=all-ones-minus-1, carry_out=1.

Optional Feature:
Macro SERIAL_ADDSUB_OVF_EN.
- Defined: the overflow register and the c_msb_in capture flop are built, and overflow behaves as described above.
- Not defined: those flops are omitted and overflow is tied to 0.
- The port is present in both builds. All other behaviour is identical.

Test Plan:
- Reset, then 0x25+0x13 (mode=0), start on E0 -> done pulses in the cycle after E8, result=0x38, carry_out=0, overflow=0, busy high for exactly 9 cycles.
- 0xFF+0x01 (mode=0) -> result=0x00, carry_out=1, overflow=0; then 0x50-0x30 (mode=1) -> result=0x20, carry_out=1, overflow=0.
- 0x30-0x50 (mode=1) -> result=0xE0, carry_out=0 (borrow), overflow=0.
- 0x7F+0x01 (mode=0) -> result=0x80, carry_out=0, overflow=1 with the macro and 0 without it.
- 0x80-0x01 (mode=1) -> result=0x7F, carry_out=1, overflow=1 with the macro.
- Start accepted, start re-pulsed on RUN cycle 2 with new operands -> ignored, original result delivered. Separately, rst=1 on RUN cycle 3 -> next edge busy=0, done=0, result=0; no done pulse. A fresh start 2 cycles later completes normally.
